// File: rtl/dm_responder.sv
// Big-endian byte-addressed data memory answering the CU's nRD/nWR strobes.
// A request completes with a one-cycle Ready (plus Err on bad requests) after WAIT_STATES+1 edges.
module dm_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        nRD,
  input  logic        nWR,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic [31:0]   dout_q;
  logic          ready_q;
  logic          err_q;
  logic [7:0]    mem_q [DEPTH_BYTES];

  logic          req;
  logic          start;
  logic          enter_done;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_data;
  logic          acc_rd;
  logic          acc_wr;
  logic          acc_err;
  logic          acc_ok;
  logic [AW-1:0] b0, b1, b2, b3;
  logic          unused_addr;

  assign req        = ~nRD | ~nWR;
  assign start      = (state_q == IDLE) & req;
  assign enter_done = (start & (WAIT_STATES == 0)) | ((state_q == WAIT) & (cnt_q == 4'd1));

  // With zero wait states the access happens on the capture edge, so it uses the live inputs.
  assign acc_addr = (state_q == IDLE) ? DAddr[AW-1:0] : addr_q;
  assign acc_data = (state_q == IDLE) ? DataIn : wdata_q;
  assign acc_rd   = (state_q == IDLE) ? ~nRD : rd_q;
  assign acc_wr   = (state_q == IDLE) ? ~nWR : wr_q;
  assign acc_err  = (acc_rd & acc_wr) | (acc_addr[1:0] != 2'b00);
  assign acc_ok   = nRST & enter_done & ~acc_err;

  assign b0 = {acc_addr[AW-1:2], 2'd0};
  assign b1 = {acc_addr[AW-1:2], 2'd1};
  assign b2 = {acc_addr[AW-1:2], 2'd2};
  assign b3 = {acc_addr[AW-1:2], 2'd3};

  assign unused_addr = ^DAddr[31:AW];

  // Storage deliberately has no reset; contents survive nRST.
  always_ff @(posedge CLK) begin
    if (acc_ok & acc_wr) begin
      mem_q[b0] <= acc_data[31:24];
      mem_q[b1] <= acc_data[23:16];
      mem_q[b2] <= acc_data[15:8];
      mem_q[b3] <= acc_data[7:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_done) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        if (acc_rd & ~acc_err) begin
          dout_q <= {mem_q[b0], mem_q[b1], mem_q[b2], mem_q[b3]};
        end
      end
      unique case (state_q)
        IDLE: if (req) begin
          addr_q  <= DAddr[AW-1:0];
          wdata_q <= DataIn;
          rd_q    <= ~nRD;
          wr_q    <= ~nWR;
          cnt_q   <= 4'(WAIT_STATES);
          state_q <= (WAIT_STATES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        // A strobe still low after completion parks us in HOLD so it cannot retrigger.
        DONE:    state_q <= req ? HOLD : IDLE;
        HOLD:    if (!req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign Ready   = ready_q;
  assign Err     = err_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (WAIT_STATES 1, 0, 3) checked against a byte-array model.
module tb_dm_responder;
  logic        clk;
  logic        nrst  [3];
  logic        nrd   [3];
  logic        nwr   [3];
  logic [31:0] daddr [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        rdy   [3];
  logic        err   [3];
  logic        busy  [3];

  int ws [3] = '{1, 0, 3};
  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  ref_mem  [3][128];
  logic [31:0] ref_dout [3];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_dout;
  } vec_t;
  vec_t tbl [13];

  dm_responder #(.DEPTH_BYTES(128), .WAIT_STATES(1)) u0 (
    .CLK(clk), .nRST(nrst[0]), .nRD(nrd[0]), .nWR(nwr[0]), .DAddr(daddr[0]), .DataIn(din[0]),
    .DataOut(dout[0]), .Ready(rdy[0]), .Err(err[0]), .Busy(busy[0]));
  dm_responder #(.DEPTH_BYTES(128), .WAIT_STATES(0)) u1 (
    .CLK(clk), .nRST(nrst[1]), .nRD(nrd[1]), .nWR(nwr[1]), .DAddr(daddr[1]), .DataIn(din[1]),
    .DataOut(dout[1]), .Ready(rdy[1]), .Err(err[1]), .Busy(busy[1]));
  dm_responder #(.DEPTH_BYTES(128), .WAIT_STATES(3)) u2 (
    .CLK(clk), .nRST(nrst[2]), .nRD(nrd[2]), .nWR(nwr[2]), .DAddr(daddr[2]), .DataIn(din[2]),
    .DataOut(dout[2]), .Ready(rdy[2]), .Err(err[2]), .Busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // One complete handshake; the strobe stays low for 'hold' extra cycles after Ready.
  task automatic access(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold);
    int n;
    int extra;
    bit seen;
    bit busy_bad;
    bit exp_err;
    int a;
    a = int'(addr % 128);
    exp_err = (addr % 4 != 0) || (rd && wr);
    @(negedge clk);
    nrd[i] = !rd; nwr[i] = !wr; daddr[i] = addr; din[i] = data;
    n = 0; seen = 0; busy_bad = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      daddr[i] = $urandom; din[i] = $urandom;
      if (rdy[i]) seen = 1;
      else if (busy[i] !== 1'b1) busy_bad = 1;
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", n, ws[i] + 1);
    chk("err_with_ready", 32'(err[i]), 32'(exp_err));
    extra = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (rdy[i]) extra++;
      if (busy[i] !== 1'b1) busy_bad = 1;
    end
    nrd[i] = 1'b1; nwr[i] = 1'b1;
    @(negedge clk);
    if (rdy[i]) extra++;
    chk("busy_while_active", 32'(busy_bad), 32'd0);
    chk("single_ready", extra, 0);
    chk("busy_idle", 32'(busy[i]), 32'd0);
    if (!exp_err) begin
      a = a - (a % 4);
      if (wr) begin
        ref_mem[i][a]   = data[31:24];
        ref_mem[i][a+1] = data[23:16];
        ref_mem[i][a+2] = data[15:8];
        ref_mem[i][a+3] = data[7:0];
      end else begin
        ref_dout[i] = {ref_mem[i][a], ref_mem[i][a+1], ref_mem[i][a+2], ref_mem[i][a+3]};
      end
    end
    chk("dout_model", dout[i], ref_dout[i]);
  endtask

  initial begin
    logic [31:0] addr;
    int n;
    bit seen;

    for (int i = 0; i < 3; i++) begin
      nrst[i] = 1'b0; nrd[i] = 1'b1; nwr[i] = 1'b1; daddr[i] = '0; din[i] = '0;
      ref_dout[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_dout", dout[i], 32'h0);
      chk("rst_ready", 32'(rdy[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      nrst[i] = 1'b1;
    end

    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 32; w++) access(i, 0, 1, 32'(w * 4), $urandom, 0);

    tbl[0]  = '{0, 1, 32'h04, 32'h11111111, 0, 32'h00000000};
    tbl[1]  = '{0, 1, 32'h08, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[2]  = '{1, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF};
    tbl[3]  = '{0, 1, 32'h06, 32'h12345678, 1, 32'hDEADBEEF};
    tbl[4]  = '{1, 0, 32'h04, 32'h0,        0, 32'h11111111};
    tbl[5]  = '{1, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF};
    tbl[6]  = '{1, 1, 32'h04, 32'h99999999, 1, 32'hDEADBEEF};
    tbl[7]  = '{1, 0, 32'h04, 32'h0,        0, 32'h11111111};
    tbl[8]  = '{0, 1, 32'h80, 32'hCAFEF00D, 0, 32'h11111111};
    tbl[9]  = '{1, 0, 32'h00, 32'h0,        0, 32'hCAFEF00D};
    tbl[10] = '{1, 0, 32'h7D, 32'h0,        1, 32'hCAFEF00D};
    tbl[11] = '{0, 1, 32'h7C, 32'h0A0B0C0D, 0, 32'hCAFEF00D};
    tbl[12] = '{1, 0, 32'hFC, 32'h0,        0, 32'h0A0B0C0D};
    for (int t = 0; t < 13; t++) begin
      access(0, tbl[t].rd, tbl[t].wr, tbl[t].addr, tbl[t].data, t % 3);
      chk($sformatf("tbl%0d_dout", t), dout[0], tbl[t].exp_dout);
      if (t == 2) begin
        chk("byte8", {24'h0, u0.mem_q[8]}, 32'hDE);
        chk("byteB", {24'h0, u0.mem_q[11]}, 32'hEF);
      end
    end

    // Zero wait states, read strobe held for five cycles in total.
    access(1, 1, 0, 32'h08, 32'h0, 4);

    for (int r = 0; r < 250; r++) begin
      int i;
      bit rd;
      bit wr;
      i = (r < 150) ? 0 : ((r < 200) ? 1 : 2);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      rd = $urandom_range(0, 1) == 1;
      wr = !rd || ($urandom_range(0, 7) == 0);
      access(i, rd, wr, addr, $urandom, $urandom_range(0, 3));
    end

    // Reset during WAIT drops the pending write.
    @(negedge clk);
    nwr[2] = 1'b0; daddr[2] = 32'h10; din[2] = 32'h55AA55AA;
    @(negedge clk);
    chk("mid_busy_before", 32'(busy[2]), 32'd1);
    @(negedge clk);
    nrst[2] = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    chk("mid_rst_ready", 32'(rdy[2]), 32'd0);
    chk("mid_rst_err", 32'(err[2]), 32'd0);
    chk("mid_rst_dout", dout[2], 32'h0);
    nwr[2] = 1'b1;
    @(negedge clk);
    nrst[2] = 1'b1;
    ref_dout[2] = '0;
    access(2, 1, 0, 32'h10, 32'h0, 0);

    // Reset while in DONE: the write has already been committed.
    @(negedge clk);
    nwr[2] = 1'b0; daddr[2] = 32'h14; din[2] = 32'h600DF00D;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[2]) seen = 1;
    end
    chk("done_ready_seen", 32'(seen), 32'd1);
    nrst[2] = 1'b0;
    #1;
    chk("done_rst_ready", 32'(rdy[2]), 32'd0);
    chk("done_rst_busy", 32'(busy[2]), 32'd0);
    nwr[2] = 1'b1;
    ref_mem[2][20] = 8'h60; ref_mem[2][21] = 8'h0D; ref_mem[2][22] = 8'hF0; ref_mem[2][23] = 8'h0D;
    @(negedge clk);
    nrst[2] = 1'b1;
    ref_dout[2] = '0;
    access(2, 1, 0, 32'h14, 32'h0, 0);
    chk("kept_write", dout[2], 32'h600DF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
